// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcodes, FSM state encoding and shared helpers
package mdu_pkg;

  localparam logic [3:0] MDU_OP_NONE  = 4'd0;
  localparam logic [3:0] MDU_OP_DIV   = 4'd1;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd2;
  localparam logic [3:0] MDU_OP_MUL   = 4'd3;
  localparam logic [3:0] MDU_OP_MULT  = 4'd4;
  localparam logic [3:0] MDU_OP_MULTU = 4'd5;
  localparam logic [3:0] MDU_OP_MFHI  = 4'd6;
  localparam logic [3:0] MDU_OP_MFLO  = 4'd7;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd8;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// rtl/mdu_div.sv - iterative unsigned restoring divider, one quotient bit per cycle
module mdu_div #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CW = $clog2(DIV_ITER) + 1;

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [32:0]   trial;
  logic          ge;

  // done_o flags the cycle in which the final step is being taken
  assign done_o = busy_q && (cnt_q == CW'(DIV_ITER - 1));
  assign quot_o = quo_q;
  assign rem_o  = rem_q;

  always_comb begin
    trial  = {rem_q, quo_q[31]};
    ge     = (trial >= {1'b0, dvs_q});
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      rem_d = ge ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + CW'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - EX-stage multiply/divide unit owning HI/LO
module mdu
  import mdu_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdu_valid_i,
  input  logic [3:0]  mdu_op_i,
  input  logic        mdu_flush_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] mul_lo_q, mul_lo_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, zdiv_q, zdiv_d;
  logic        div_start, div_done;
  logic [31:0] quot, rem, div_dividend, div_divisor;
  logic        ext_a, ext_b;
  logic [63:0] prod;

  // Low 64 bits of the 33x33 product equal the low 64 bits of a 64x64 one
  assign ext_a = (op_q != MDU_OP_MULTU) & a_q[31];
  assign ext_b = (op_q != MDU_OP_MULTU) & b_q[31];
  assign prod  = {{32{ext_a}}, a_q} * {{32{ext_b}}, b_q};

  assign div_dividend = (mdu_op_i == MDU_OP_DIV) ? abs32(a_i) : a_i;
  assign div_divisor  = (mdu_op_i == MDU_OP_DIV) ? abs32(b_i) : b_i;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

  mdu_div #(.DIV_ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (div_start),
    .abort_i   (mdu_flush_i),
    .dividend_i(div_dividend),
    .divisor_i (div_divisor),
    .done_o    (div_done),
    .quot_o    (quot),
    .rem_o     (rem)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_lo_d  = mul_lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zdiv_d    = zdiv_q;
    div_start = 1'b0;
    stall_o   = 1'b0;
    result_o  = '0;
    case (state_q)
      S_IDLE: if (mdu_valid_i) begin
        case (mdu_op_i)
          MDU_OP_DIV, MDU_OP_DIVU: begin
            stall_o   = 1'b1;
            op_d      = mdu_op_i;
            a_d       = a_i;
            zdiv_d    = (b_i == '0);
            neg_quo_d = (mdu_op_i == MDU_OP_DIV) & (a_i[31] ^ b_i[31]);
            neg_rem_d = (mdu_op_i == MDU_OP_DIV) & a_i[31];
            if (b_i == '0) begin
              state_d = S_FIX;
            end else begin
              state_d   = S_DIV;
              div_start = 1'b1;
            end
          end
          MDU_OP_MUL, MDU_OP_MULT, MDU_OP_MULTU: begin
            stall_o = 1'b1;
            op_d    = mdu_op_i;
            a_d     = a_i;
            b_d     = b_i;
            state_d = S_MUL;
          end
          MDU_OP_MFHI: result_o = hi_q;
          MDU_OP_MFLO: result_o = lo_q;
          MDU_OP_MTHI: hi_d = a_i;
          MDU_OP_MTLO: lo_d = a_i;
          default: ;
        endcase
      end
      S_MUL: begin
        stall_o = 1'b1;
        state_d = S_DONE;
        if (op_q == MDU_OP_MUL) begin
          mul_lo_d = prod[31:0];
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (div_done) state_d = S_FIX;
      end
      S_FIX: begin
        stall_o = 1'b1;
        state_d = S_DONE;
        if (zdiv_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = neg_quo_q ? (~quot + 32'd1) : quot;
          hi_d = neg_rem_q ? (~rem + 32'd1) : rem;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (op_q == MDU_OP_MUL) result_o = mul_lo_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (mdu_flush_i) begin
      state_d   = S_IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      stall_o   = 1'b0;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= MDU_OP_NONE;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_lo_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zdiv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_lo_q  <= mul_lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zdiv_q    <= zdiv_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard bench for the multiply/divide unit
module tb_mdu;
  import mdu_pkg::*;

  typedef struct {
    int          tag;
    int          stalls;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  op;
  logic        flush;
  logic [31:0] a, b;
  logic [31:0] result, hi, lo;
  logic        stall;

  exp_t        long_q[$];
  logic [31:0] fast_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mdu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdu_valid_i(valid),
    .mdu_op_i   (op),
    .mdu_flush_i(flush),
    .a_i        (a),
    .b_i        (b),
    .result_o   (result),
    .stall_o    (stall),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_long(input int tag, input int stalls, input logic [31:0] h,
                           input logic [31:0] l, input logic [31:0] r);
    exp_t e;
    e.tag = tag; e.stalls = stalls; e.hi = h; e.lo = l; e.res = r;
    long_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    valid = 1'b1; op = o; a = x; b = y;
  endtask

  task automatic wait_retire();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (stall && k < 100);
    if (stall) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_timeout: stall_o still high after %0d cycles, required low", k);
    end
  endtask

  // Issue in the cycle after the next posedge; stalls=0 means single-cycle op
  task automatic issue(input int tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int stalls, input logic [31:0] h,
                       input logic [31:0] l, input logic [31:0] r);
    if (o == MDU_OP_MFHI || o == MDU_OP_MFLO) fast_q.push_back(r);
    else if (stalls > 0) push_long(tag, stalls, h, l, r);
    @(posedge clk); #1;
    drive(o, x, y);
    wait_retire();
  endtask

  // Monitor: a falling stall_o marks retirement (DONE, flush or reset)
  initial begin
    int   run = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (long_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_retire: stall ran %0d cycles, no op expected", run);
        end else begin
          e = long_q.pop_front();
          check($sformatf("op%0d_stall_cycles", e.tag), 32'(run), 32'(e.stalls));
          check($sformatf("op%0d_hi", e.tag), hi, e.hi);
          check($sformatf("op%0d_lo", e.tag), lo, e.lo);
          check($sformatf("op%0d_result", e.tag), result, e.res);
        end
        run = 0;
      end
      if (rst_n && valid && !stall && (op == MDU_OP_MFHI || op == MDU_OP_MFLO)) begin
        if (fast_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_move: result %h with no expectation", result);
        end else begin
          check("mf_result", result, fast_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; op = MDU_OP_NONE; flush = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_result", result, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(1, MDU_OP_MULT,  32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0);
    issue(2, MDU_OP_MULTU, 32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA, 32'h0);
    issue(3, MDU_OP_MUL,   32'hFFFF_FFFE, 32'd3, 2, 32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFA);
    issue(4, MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0);
    issue(5, MDU_OP_DIVU,  32'd7, 32'd2, 34, 32'd1, 32'd3, 32'h0);
    issue(6, MDU_OP_DIV,   32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 32'h0);
    issue(7, MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 32'h0);
    issue(8, MDU_OP_DIVU,  32'd100, 32'd7, 34, 32'd2, 32'd14, 32'h0);
    issue(9, MDU_OP_MTHI,  32'h1234, 32'd0, 0, 32'h0, 32'h0, 32'h0);
    issue(10, MDU_OP_MFHI, 32'd0, 32'd0, 0, 32'h0, 32'h0, 32'h1234);

    // Preload HI/LO, then flush a DIVU ten cycles after issue
    issue(11, MDU_OP_MTHI, 32'd1, 32'd0, 0, 32'h0, 32'h0, 32'h0);
    issue(12, MDU_OP_MTLO, 32'd2, 32'd0, 0, 32'h0, 32'h0, 32'h0);
    push_long(13, 10, 32'd1, 32'd2, 32'h0);
    @(posedge clk); #1;
    drive(MDU_OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    push_long(14, 2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'h0);
    drive(MDU_OP_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_retire();

    // Asynchronous reset five cycles into a DIV
    push_long(15, 5, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(MDU_OP_DIV, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0; valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    issue(16, MDU_OP_MULTU, 32'h0001_0000, 32'h0001_0000, 2, 32'd1, 32'd0, 32'h0);
    issue(17, MDU_OP_MTLO, 32'd5, 32'd0, 0, 32'h0, 32'h0, 32'h0);
    issue(18, MDU_OP_MFLO, 32'd0, 32'd0, 0, 32'h0, 32'h0, 32'd5);
    @(posedge clk); #1 valid = 1'b0; op = MDU_OP_NONE;
    repeat (4) @(negedge clk);
    check("long_queue_drained", 32'(long_q.size()), 32'd0);
    check("fast_queue_drained", 32'(fast_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
